// File: rtl/bnn_seq_stream.sv
// bnn_seq_stream: sequential two-layer binary NN classifier with valid/ready I/O.
// Define BNN_SEQ_SUMS_EN to expose the final layer-2 class sums on port sums.
module bnn_seq_stream #(
  parameter int N = 11,
  parameter int M = 40,
  parameter int B = 4,
  parameter int C = 6,
  parameter logic [N*M-1:0] W1 = {N*M{1'b1}},
  parameter logic [M*C-1:0] W2 = {M*C{1'b1}},
  localparam int KW = (C > 1) ? $clog2(C) : 1,
  localparam int SW = $clog2(M+1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [B*N-1:0] data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [KW-1:0]  klass,
  output logic           out_valid,
  input  logic           out_ready
`ifdef BNN_SEQ_SUMS_EN
  ,
  output logic [C*SW-1:0] sums
`endif
);

  localparam int AW = B + $clog2(N) + 1;
  localparam int MX = (N > M) ? ((N > C) ? N : C)
                              : ((M > C) ? M : C);
  localparam int CW = (MX > 1) ? $clog2(MX) : 1;

  typedef enum logic [2:0] {
    IDLE, L1, L2, ARG, DONE
  } state_t;

  state_t               st_q;
  logic [B*N-1:0]       data_q;
  logic signed [AW-1:0] acc_q [M];
  logic [SW-1:0]        sum_q [C];
  logic [SW-1:0]        best_q;
  logic [CW-1:0]        cnt_q;
  logic [KW-1:0]        klass_q;
  logic                 ov_q;

  logic                 accept;
  logic signed [AW-1:0] feat;
  logic                 h_cur;
  logic [SW-1:0]        cur_sum;
  logic [M-1:0]         w1_col;
  logic [C-1:0]         w2_col;

  assign in_ready  = (st_q == IDLE) | ((st_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign klass     = klass_q;
  assign out_valid = ov_q;

  // The shared counter picks the feature, hidden neuron or class in turn.
  always_comb begin
    feat    = '0;
    h_cur   = 1'b0;
    cur_sum = '0;
    w1_col  = '0;
    w2_col  = '0;
    for (int n = 0; n < N; n++) begin
      if (cnt_q == CW'(n)) begin
        feat = AW'(data_q[n*B +: B]);
        for (int m = 0; m < M; m++) w1_col[m] = W1[m*N+n];
      end
    end
    for (int m = 0; m < M; m++) begin
      if (cnt_q == CW'(m)) begin
        h_cur = ~acc_q[m][AW-1];
        for (int c = 0; c < C; c++) w2_col[c] = W2[c*M+m];
      end
    end
    for (int c = 0; c < C; c++) begin
      if (cnt_q == CW'(c)) cur_sum = sum_q[c];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= IDLE;
      data_q  <= '0;
      best_q  <= '0;
      cnt_q   <= '0;
      klass_q <= '0;
      ov_q    <= 1'b0;
      for (int m = 0; m < M; m++) acc_q[m] <= '0;
      for (int c = 0; c < C; c++) sum_q[c] <= '0;
    end else begin
      unique case (st_q)
        IDLE, DONE: begin
          if (st_q == DONE && out_ready) begin
            ov_q <= 1'b0;
            st_q <= IDLE;
          end
          if (accept) begin
            data_q <= data;
            cnt_q  <= '0;
            st_q   <= L1;
            for (int m = 0; m < M; m++) acc_q[m] <= '0;
            for (int c = 0; c < C; c++) sum_q[c] <= '0;
          end
        end
        L1: begin
          for (int m = 0; m < M; m++)
            acc_q[m] <= w1_col[m] ? acc_q[m] + feat
                                  : acc_q[m] - feat;
          if (cnt_q == CW'(N-1)) begin
            cnt_q <= '0;
            st_q  <= L2;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        L2: begin
          for (int c = 0; c < C; c++)
            sum_q[c] <= sum_q[c] + SW'(~(h_cur ^ w2_col[c]));
          if (cnt_q == CW'(M-1)) begin
            cnt_q <= '0;
            st_q  <= ARG;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ARG: begin
          if (cnt_q == '0 || cur_sum > best_q) begin
            best_q  <= cur_sum;
            klass_q <= KW'(cnt_q);
          end
          if (cnt_q == CW'(C-1)) begin
            cnt_q <= '0;
            ov_q  <= 1'b1;
            st_q  <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

`ifdef BNN_SEQ_SUMS_EN
  always_comb begin
    sums = '0;
    for (int c = 0; c < C; c++) sums[c*SW +: SW] = sum_q[c];
  end
`endif

endmodule

// File: tb/tb_bnn_seq_stream.sv
// Scoreboard bench for bnn_seq_stream: default instance plus a small 2/2/4/3 instance.
// Expected class, sums and latency come from constants and a reference model.
module tb_bnn_seq_stream;

  localparam int LAT0 = 57;
  localparam int LAT1 = 7;
  localparam logic [3:0] T1W1 = 4'b0101;
  localparam logic [5:0] T1W2 = 6'b010011;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [43:0] d0_data;
  logic        d0_iv, d0_ir, d0_ov, d0_or;
  logic [2:0]  d0_k;
  logic [7:0]  d1_data;
  logic        d1_iv, d1_ir, d1_ov, d1_or;
  logic [1:0]  d1_k;
`ifdef BNN_SEQ_SUMS_EN
  logic [35:0] d0_sums;
  logic [5:0]  d1_sums;
`endif

  bnn_seq_stream dut0 (
    .clk(clk), .rst(rst), .data(d0_data),
    .in_valid(d0_iv), .in_ready(d0_ir),
    .klass(d0_k), .out_valid(d0_ov), .out_ready(d0_or)
`ifdef BNN_SEQ_SUMS_EN
    , .sums(d0_sums)
`endif
  );

  bnn_seq_stream #(
    .N(2), .M(2), .B(4), .C(3), .W1(T1W1), .W2(T1W2)
  ) dut1 (
    .clk(clk), .rst(rst), .data(d1_data),
    .in_valid(d1_iv), .in_ready(d1_ir),
    .klass(d1_k), .out_valid(d1_ov), .out_ready(d1_or)
`ifdef BNN_SEQ_SUMS_EN
    , .sums(d1_sums)
`endif
  );

  int         n_vec = 0;
  int         n_bad = 0;
  int         q0_t[$];
  int         q1_t[$];
  int         q1_k[$];
  logic [5:0] q1_s[$];
  bit         pv0 = 1'b0;
  bit         pv1 = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model1(input logic [7:0] d, output int k,
                                 output logic [5:0] s);
    logic [3:0] w1 = T1W1;
    logic [5:0] w2 = T1W2;
    logic [1:0] h;
    int acc;
    int sm [3];
    for (int m = 0; m < 2; m++) begin
      acc = 0;
      for (int n = 0; n < 2; n++) begin
        if (w1[m*2+n]) acc += int'(d[n*4 +: 4]);
        else           acc -= int'(d[n*4 +: 4]);
      end
      h[m] = (acc >= 0);
    end
    for (int c = 0; c < 3; c++) begin
      sm[c] = 0;
      for (int m = 0; m < 2; m++)
        if (h[m] == w2[c*2+m]) sm[c]++;
    end
    k = 0;
    for (int c = 1; c < 3; c++)
      if (sm[c] > sm[k]) k = c;
    s = {2'(sm[2]), 2'(sm[1]), 2'(sm[0])};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      pv0 = 1'b0;
    end else begin
      if (d0_ov && !pv0) begin
        if (q0_t.size() == 0) chk("d0_spurious", d0_ov, 0);
        else chk("d0_latency", cyc - q0_t[0], LAT0);
      end
      if (d0_ov && d0_or) begin
        if (q0_t.size() == 0) begin
          chk("d0_extra", d0_ov, 0);
        end else begin
          chk("d0_klass", d0_k, 0);
`ifdef BNN_SEQ_SUMS_EN
          chk("d0_sums", d0_sums, {6{6'd40}});
`endif
          void'(q0_t.pop_front());
        end
      end
      pv0 = d0_ov && !d0_or;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      pv1 = 1'b0;
    end else begin
      if (d1_ov && !pv1) begin
        if (q1_t.size() == 0) chk("d1_spurious", d1_ov, 0);
        else chk("d1_latency", cyc - q1_t[0], LAT1);
      end
      if (d1_ov && d1_or) begin
        if (q1_k.size() == 0) begin
          chk("d1_extra", d1_ov, 0);
        end else begin
          chk("d1_klass", d1_k, q1_k.pop_front());
`ifdef BNN_SEQ_SUMS_EN
          chk("d1_sums", d1_sums, q1_s[0]);
`endif
          void'(q1_s.pop_front());
          void'(q1_t.pop_front());
        end
      end
      pv1 = d1_ov && !d1_or;
    end
  end

  task automatic send0(input logic [43:0] d);
    int t = 0;
    d0_data = d;
    d0_iv   = 1'b1;
    @(negedge clk);
    while (!d0_ir && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("d0_accept", d0_ir, 1);
    if (d0_ir) q0_t.push_back(cyc + 1);
    @(posedge clk);
    #1;
    d0_iv   = 1'b0;
    d0_data = 44'({$urandom, $urandom});
  endtask

  task automatic send1(input logic [7:0] d, input int k,
                       input logic [5:0] s);
    int t = 0;
    d1_data = d;
    d1_iv   = 1'b1;
    @(negedge clk);
    while (!d1_ir && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("d1_accept", d1_ir, 1);
    if (d1_ir) begin
      q1_t.push_back(cyc + 1);
      q1_k.push_back(k);
      q1_s.push_back(s);
    end
    @(posedge clk);
    #1;
    d1_iv   = 1'b0;
    d1_data = 8'($urandom);
  endtask

  task automatic drain(input int lim);
    int t = 0;
    while ((q0_t.size() != 0 || q1_t.size() != 0) && t < lim) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", q0_t.size() + q1_t.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    rst = 1'b1;
    d0_data = '0; d0_iv = 1'b0; d0_or = 1'b1;
    d1_data = '0; d1_iv = 1'b0; d1_or = 1'b1;
    #13;
    chk("rst_d0_ir", d0_ir, 1);
    chk("rst_d0_ov", d0_ov, 0);
    chk("rst_d0_k", d0_k, 0);
    chk("rst_d1_ir", d1_ir, 1);
    chk("rst_d1_ov", d1_ov, 0);
    chk("rst_d1_k", d1_k, 0);
`ifdef BNN_SEQ_SUMS_EN
    chk("rst_d1_sums", d1_sums, 0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;

    send0(44'h46012229a22);
    drain(200);

    send1(8'h53, 1, 6'b01_10_00);
    send1(8'h35, 0, 6'b01_00_10);
    send1(8'h44, 0, 6'b01_00_10);
    drain(100);

    d1_or = 1'b0;
    send1(8'h53, 1, 6'b01_10_00);
    t = 0;
    @(negedge clk);
    while (!d1_ov && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("stall_rise", d1_ov, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_ov", d1_ov, 1);
      chk("stall_k", d1_k, 1);
      chk("stall_ir", d1_ir, 0);
    end
    @(posedge clk);
    #1;
    d1_or = 1'b1;
    send1(8'h35, 0, 6'b01_00_10);
    chk("b2b_ov_fall", d1_ov, 0);
    chk("b2b_ir", d1_ir, 0);
    drain(100);

    send0(44'h123456789ab);
    repeat (16) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_ir", d0_ir, 1);
    chk("abort_ov", d0_ov, 0);
    chk("abort_k", d0_k, 0);
    rst = 1'b0;
    q0_t.delete();
    repeat (70) @(posedge clk);
    #1;
    send0(44'({$urandom, $urandom}));
    drain(200);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] d;
      logic [5:0] s;
      int k;
      d = 8'($urandom);
      model1(d, k, s);
      send1(d, k, s);
    end
    drain(600);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
